// File: rtl/f_fetch_unit.sv
// Fetch stage of the five-stage MIPS core: holds the fetch PC, reads instruction memory
// over a req/ack handshake, and owns the F/D pipeline register that feeds decode.
// Fetch-address errors (misaligned or outside the instruction region) skip memory and
// travel down the pipe as a nop slot tagged with an address-error flag.
module f_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_SIZE  = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        reset_n,
    // Next-PC path from decode and hazard unit
    input  logic [31:0] NPC,
    input  logic        D_stall,
    // Instruction memory
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    // Fetch status
    output logic [31:0] F_PC,
    output logic        F_busy,
    // F/D register
    output logic [31:0] D_PC,
    output logic [31:0] D_instr,
    output logic        D_valid,
    output logic        D_exc_adel
);

    // StReq: fetching F_PC. StHold: word parked in fbuf until D can take it.
    typedef enum logic [0:0] {
        StReq,
        StHold
    } state_e;

    localparam logic [31:0] NopInstr = 32'h0000_0000;

    state_e      state_q, state_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic [31:0] fbuf_q, fbuf_d;
    logic        fbuf_exc_q, fbuf_exc_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic        d_valid_q, d_valid_d;
    logic        d_exc_adel_q, d_exc_adel_d;

    logic [31:0] pc_offset;
    logic        pc_misaligned;
    logic        pc_below_base;
    logic        pc_beyond_top;
    logic        adel;
    logic        got;
    logic [31:0] fetch_word;
    logic        advance;

    // Address-error decode on the current fetch PC. The offset form avoids overflow when
    // IM_BASE + IM_SIZE wraps past the top of the address space.
    always_comb begin
        pc_offset     = f_pc_q - IM_BASE;
        pc_misaligned = (f_pc_q[1:0] != 2'b00);
        pc_below_base = (f_pc_q < IM_BASE);
        pc_beyond_top = (pc_offset >= IM_SIZE);
        adel          = pc_misaligned || pc_below_base || pc_beyond_top;
    end

    // Memory handshake and fetch status; an address error behaves like an instant ack
    // of a nop, so it never reaches the memory.
    always_comb begin
        im_req     = (state_q == StReq) && !adel;
        im_addr    = f_pc_q;
        F_busy     = im_req && !im_ack;
        got        = (state_q == StReq) && (im_ack || adel);
        fetch_word = adel ? NopInstr : im_rdata;
    end

    // Fetch-side next state: PC update, fbuf capture and REQ/HOLD sequencing.
    always_comb begin
        state_d    = state_q;
        f_pc_d     = f_pc_q;
        fbuf_d     = fbuf_q;
        fbuf_exc_d = fbuf_exc_q;
        advance    = 1'b0;

        unique case (state_q)
            StReq: begin
                if (got && !D_stall) begin
                    // Word goes straight into D; NPC is taken only here and in HOLD release.
                    advance = 1'b1;
                    f_pc_d  = NPC;
                end else if (got && D_stall) begin
                    // D is busy: park the word so the memory is not asked again.
                    fbuf_d     = fetch_word;
                    fbuf_exc_d = adel;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (!D_stall) begin
                    advance = 1'b1;
                    f_pc_d  = NPC;
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StReq;
            end
        endcase
    end

    // F/D register next state: load on advance, bubble when fetch stalls on memory alone.
    always_comb begin
        d_pc_d       = d_pc_q;
        d_instr_d    = d_instr_q;
        d_valid_d    = d_valid_q;
        d_exc_adel_d = d_exc_adel_q;

        if (advance) begin
            d_pc_d    = f_pc_q;
            d_valid_d = 1'b1;
            if (state_q == StHold) begin
                d_instr_d    = fbuf_q;
                d_exc_adel_d = fbuf_exc_q;
            end else begin
                d_instr_d    = fetch_word;
                d_exc_adel_d = adel;
            end
        end else if ((state_q == StReq) && !got && !D_stall) begin
            // Waiting on memory while D moves on: insert a nop, keep D_PC for reference.
            d_instr_d    = NopInstr;
            d_valid_d    = 1'b0;
            d_exc_adel_d = 1'b0;
        end
    end

    // State registers; reset drops any outstanding fetch and restarts at RESET_PC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StReq;
            f_pc_q       <= RESET_PC;
            fbuf_q       <= 32'h0;
            fbuf_exc_q   <= 1'b0;
            d_pc_q       <= 32'h0;
            d_instr_q    <= 32'h0;
            d_valid_q    <= 1'b0;
            d_exc_adel_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            f_pc_q       <= f_pc_d;
            fbuf_q       <= fbuf_d;
            fbuf_exc_q   <= fbuf_exc_d;
            d_pc_q       <= d_pc_d;
            d_instr_q    <= d_instr_d;
            d_valid_q    <= d_valid_d;
            d_exc_adel_q <= d_exc_adel_d;
        end
    end

    // Registered outputs.
    always_comb begin
        F_PC       = f_pc_q;
        D_PC       = d_pc_q;
        D_instr    = d_instr_q;
        D_valid    = d_valid_q;
        D_exc_adel = d_exc_adel_q;
    end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Self-checking bench for f_fetch_unit: directed scenarios followed by random traffic,
// all compared against a slot-level model of the fetch stage kept in this file.
module tb_f_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_SIZE  = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] NPC = 32'h0;
    logic        D_stall = 1'b0;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack = 1'b0;
    logic [31:0] im_rdata;
    logic [31:0] F_PC;
    logic        F_busy;
    logic [31:0] D_PC;
    logic [31:0] D_instr;
    logic        D_valid;
    logic        D_exc_adel;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory content is a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign im_rdata = mem_word(im_addr);

    f_fetch_unit #(
        .RESET_PC (RESET_PC),
        .IM_BASE  (IM_BASE),
        .IM_SIZE  (IM_SIZE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .NPC        (NPC),
        .D_stall    (D_stall),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_ack     (im_ack),
        .im_rdata   (im_rdata),
        .F_PC       (F_PC),
        .F_busy     (F_busy),
        .D_PC       (D_PC),
        .D_instr    (D_instr),
        .D_valid    (D_valid),
        .D_exc_adel (D_exc_adel)
    );

    // ---------------- reference model ----------------
    // pend holds a fetched slot {exc, word} that D has not yet accepted (0 or 1 entries).
    logic [31:0] m_fpc;
    logic [32:0] pend[$];
    logic [31:0] md_pc, md_instr;
    logic        md_valid, md_exc;
    logic        exp_req, exp_busy;
    logic [31:0] exp_addr;
    logic        obs_req, obs_busy;
    logic [31:0] obs_addr;

    function automatic logic addr_err(input logic [31:0] pc);
        logic [32:0] top;
        top = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
        return (pc % 4 != 0) || (pc < IM_BASE) || ({1'b0, pc} >= top);
    endfunction

    task automatic model_reset();
        m_fpc = RESET_PC;
        pend.delete();
        md_pc = 32'h0;
        md_instr = 32'h0;
        md_valid = 1'b0;
        md_exc = 1'b0;
    endtask

    // One clock: drive inputs at negedge, capture combinational outputs, advance the model.
    task automatic tick(input logic stall, input logic ack, input logic [31:0] npc);
        logic        err;
        logic [31:0] word;
        logic [32:0] slot;
        @(negedge clk);
        D_stall = stall;
        im_ack = ack;
        NPC = npc;
        #1;
        err = addr_err(m_fpc);
        exp_req = (pend.size() == 0) && !err;
        exp_busy = exp_req && !ack;
        exp_addr = m_fpc;
        obs_req = im_req;
        obs_busy = F_busy;
        obs_addr = im_addr;
        @(posedge clk);
        if (pend.size() == 0) begin
            if (ack || err) begin
                word = err ? 32'h0 : mem_word(m_fpc);
                if (stall) begin
                    pend.push_back({err, word});
                end else begin
                    md_pc = m_fpc; md_instr = word; md_valid = 1'b1; md_exc = err;
                    m_fpc = npc;
                end
            end else if (!stall) begin
                md_instr = 32'h0; md_valid = 1'b0; md_exc = 1'b0;
            end
        end else if (!stall) begin
            slot = pend.pop_front();
            md_pc = m_fpc; md_instr = slot[31:0]; md_valid = 1'b1; md_exc = slot[32];
            m_fpc = npc;
        end
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        D_stall = 1'b0;
        im_ack = 1'b0;
        NPC = 32'h0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        im_ack = 1'b0;
        D_stall = 1'b0;
        @(posedge clk);
        #1;
        checks += 6;
        if (F_PC !== 32'h3000) begin failures++; $display("FAIL reset_fpc: got %h want %h", F_PC, 32'h3000); end
        if (im_req !== 1'b1) begin failures++; $display("FAIL reset_req: got %b want 1", im_req); end
        if (im_addr !== 32'h3000) begin failures++; $display("FAIL reset_addr: got %h want %h", im_addr, 32'h3000); end
        if (D_valid !== 1'b0) begin failures++; $display("FAIL reset_dvalid: got %b want 0", D_valid); end
        if (D_instr !== 32'h0) begin failures++; $display("FAIL reset_dinstr: got %h want 0", D_instr); end
        if (F_busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b want 1", F_busy); end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, m_fpc + 32'd4);
            checks += 5;
            if (D_PC !== 32'h3000 + 4 * i) begin failures++; $display("FAIL stream_dpc[%0d]: got %h want %h", i, D_PC, 32'h3000 + 4 * i); end
            if (D_instr !== mem_word(32'h3000 + 4 * i)) begin failures++; $display("FAIL stream_dinstr[%0d]: got %h want %h", i, D_instr, mem_word(32'h3000 + 4 * i)); end
            if (D_valid !== 1'b1) begin failures++; $display("FAIL stream_dvalid[%0d]: got %b want 1", i, D_valid); end
            if (obs_req !== 1'b1) begin failures++; $display("FAIL stream_req[%0d]: got %b want 1", i, obs_req); end
            if (obs_busy !== 1'b0) begin failures++; $display("FAIL stream_busy[%0d]: got %b want 0", i, obs_busy); end
        end
    endtask

    task automatic test_wait_states();
        apply_reset();
        tick(1'b0, 1'b1, 32'h3004);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 32'h3008);
            checks += 3;
            if (obs_busy !== 1'b1) begin failures++; $display("FAIL wait_busy[%0d]: got %b want 1", i, obs_busy); end
            if (D_valid !== 1'b0) begin failures++; $display("FAIL wait_dvalid[%0d]: got %b want 0", i, D_valid); end
            if (D_instr !== 32'h0) begin failures++; $display("FAIL wait_dinstr[%0d]: got %h want 0", i, D_instr); end
        end
        tick(1'b0, 1'b1, 32'h3008);
        checks += 4;
        if (obs_busy !== 1'b0) begin failures++; $display("FAIL wait_ack_busy: got %b want 0", obs_busy); end
        if (D_PC !== 32'h3004) begin failures++; $display("FAIL wait_dpc: got %h want %h", D_PC, 32'h3004); end
        if (D_instr !== mem_word(32'h3004)) begin failures++; $display("FAIL wait_dinstr: got %h want %h", D_instr, mem_word(32'h3004)); end
        if (F_PC !== 32'h3008) begin failures++; $display("FAIL wait_fpc: got %h want %h", F_PC, 32'h3008); end
    endtask

    task automatic test_stall_on_ack();
        tick(1'b1, 1'b1, 32'h3100);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick(1'b1, 1'($urandom % 2), 32'h3100);
            checks += 3;
            if (i > 0 && obs_req !== 1'b0) begin failures++; $display("FAIL stall_req[%0d]: got %b want 0", i, obs_req); end
            if (D_PC !== 32'h3004) begin failures++; $display("FAIL stall_dpc[%0d]: got %h want %h", i, D_PC, 32'h3004); end
            if (F_PC !== 32'h3008) begin failures++; $display("FAIL stall_fpc[%0d]: got %h want %h", i, F_PC, 32'h3008); end
        end
        tick(1'b0, 1'b0, 32'h3010);
        checks += 5;
        if (obs_req !== 1'b0) begin failures++; $display("FAIL release_req: got %b want 0", obs_req); end
        if (D_PC !== 32'h3008) begin failures++; $display("FAIL release_dpc: got %h want %h", D_PC, 32'h3008); end
        if (D_instr !== mem_word(32'h3008)) begin failures++; $display("FAIL release_dinstr: got %h want %h", D_instr, mem_word(32'h3008)); end
        if (D_valid !== 1'b1) begin failures++; $display("FAIL release_dvalid: got %b want 1", D_valid); end
        if (F_PC !== 32'h3010) begin failures++; $display("FAIL release_fpc: got %h want %h", F_PC, 32'h3010); end
    endtask

    task automatic test_fetch_errors();
        tick(1'b0, 1'b1, 32'h3002);
        tick(1'b0, 1'b0, 32'h7000);
        checks += 5;
        if (obs_req !== 1'b0) begin failures++; $display("FAIL mis_req: got %b want 0", obs_req); end
        if (D_exc_adel !== 1'b1) begin failures++; $display("FAIL mis_exc: got %b want 1", D_exc_adel); end
        if (D_instr !== 32'h0) begin failures++; $display("FAIL mis_dinstr: got %h want 0", D_instr); end
        if (D_PC !== 32'h3002) begin failures++; $display("FAIL mis_dpc: got %h want %h", D_PC, 32'h3002); end
        if (D_valid !== 1'b1) begin failures++; $display("FAIL mis_dvalid: got %b want 1", D_valid); end
        tick(1'b0, 1'b0, 32'h3014);
        checks += 5;
        if (obs_req !== 1'b0) begin failures++; $display("FAIL oor_req: got %b want 0", obs_req); end
        if (D_exc_adel !== 1'b1) begin failures++; $display("FAIL oor_exc: got %b want 1", D_exc_adel); end
        if (D_instr !== 32'h0) begin failures++; $display("FAIL oor_dinstr: got %h want 0", D_instr); end
        if (D_PC !== 32'h7000) begin failures++; $display("FAIL oor_dpc: got %h want %h", D_PC, 32'h7000); end
        if (F_PC !== 32'h3014) begin failures++; $display("FAIL oor_fpc: got %h want %h", F_PC, 32'h3014); end
    endtask

    task automatic test_reset_mid_wait();
        tick(1'b0, 1'b0, 32'h3018);
        checks += 2;
        if (obs_busy !== 1'b1) begin failures++; $display("FAIL midwait_busy: got %b want 1", obs_busy); end
        if (D_valid !== 1'b0) begin failures++; $display("FAIL midwait_dvalid: got %b want 0", D_valid); end
        @(negedge clk);
        im_ack = 1'b0;
        reset_n = 1'b0;
        #1;
        checks += 6;
        if (F_PC !== 32'h3000) begin failures++; $display("FAIL rst_async_fpc: got %h want %h", F_PC, 32'h3000); end
        if (im_req !== 1'b1) begin failures++; $display("FAIL rst_async_req: got %b want 1", im_req); end
        if (D_valid !== 1'b0) begin failures++; $display("FAIL rst_async_dvalid: got %b want 0", D_valid); end
        if (D_PC !== 32'h0) begin failures++; $display("FAIL rst_async_dpc: got %h want 0", D_PC); end
        if (D_instr !== 32'h0) begin failures++; $display("FAIL rst_async_dinstr: got %h want 0", D_instr); end
        if (D_exc_adel !== 1'b0) begin failures++; $display("FAIL rst_async_exc: got %b want 0", D_exc_adel); end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        tick(1'b0, 1'b1, 32'h3004);
        checks += 2;
        if (obs_addr !== 32'h3000) begin failures++; $display("FAIL post_rst_addr: got %h want %h", obs_addr, 32'h3000); end
        if (D_PC !== 32'h3000) begin failures++; $display("FAIL post_rst_dpc: got %h want %h", D_PC, 32'h3000); end
    endtask

    task automatic test_random();
        logic        stall, ack;
        logic [31:0] npc;
        int          pick;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom % 10) < 3;
            ack = ($urandom % 10) < 6;
            pick = $urandom % 20;
            if (pick < 14) npc = m_fpc + 32'd4;
            else if (pick < 17) npc = IM_BASE + ($urandom_range(0, 4095) << 2);
            else npc = $urandom;
            tick(stall, ack, npc);
            checks += 8;
            if (obs_req !== exp_req) begin failures++; $display("FAIL rnd_req[%0d]: got %b want %b", i, obs_req, exp_req); end
            if (obs_busy !== exp_busy) begin failures++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, obs_busy, exp_busy); end
            if (obs_addr !== exp_addr) begin failures++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, obs_addr, exp_addr); end
            if (F_PC !== m_fpc) begin failures++; $display("FAIL rnd_fpc[%0d]: got %h want %h", i, F_PC, m_fpc); end
            if (D_PC !== md_pc) begin failures++; $display("FAIL rnd_dpc[%0d]: got %h want %h", i, D_PC, md_pc); end
            if (D_instr !== md_instr) begin failures++; $display("FAIL rnd_dinstr[%0d]: got %h want %h", i, D_instr, md_instr); end
            if (D_valid !== md_valid) begin failures++; $display("FAIL rnd_dvalid[%0d]: got %b want %b", i, D_valid, md_valid); end
            if (D_exc_adel !== md_exc) begin failures++; $display("FAIL rnd_exc[%0d]: got %b want %b", i, D_exc_adel, md_exc); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_wait_states();
        test_stall_on_ack();
        test_fetch_errors();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
